// File: rtl/matrix_ewise_engine_pkg.sv
// Shared types and the element-wise ALU for the matrix element-wise engine.
package matrix_ewise_engine_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        EwAdd = 2'd0,
        EwSub = 2'd1,
        EwMul = 2'd2,
        EwMax = 2'd3
    } ewise_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } ewise_state_t;

    localparam int unsigned EWISE_MAX_RD_LAT = 4;

    // ADD/SUB/MUL wrap modulo 2^32; MAX compares as signed.
    function automatic word_t ewise_alu(ewise_op_t op, word_t a, word_t b);
        word_t r;
        case (op)
            EwAdd:   r = a + b;
            EwSub:   r = a - b;
            EwMul:   r = a * b;
            default: r = ($signed(a) > $signed(b)) ? a : b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/matrix_ewise_engine_if.sv
// Banked per-lane scratch-memory bus between the engine and the memory.
interface matrix_ewise_engine_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned AW    = 6
);
    import matrix_ewise_engine_pkg::*;

    logic [LANES-1:0]           mem_ren;
    logic [LANES-1:0][AW-1:0]   mem_raddrA;
    logic [LANES-1:0][AW-1:0]   mem_raddrB;
    word_t [LANES-1:0]          mem_rdataA;
    word_t [LANES-1:0]          mem_rdataB;
    logic [LANES-1:0]           mem_wen;
    logic [LANES-1:0][AW-1:0]   mem_waddr;
    word_t [LANES-1:0]          mem_wdata;

    modport master (
        output mem_ren, mem_raddrA, mem_raddrB, mem_wen, mem_waddr, mem_wdata,
        input  mem_rdataA, mem_rdataB
    );

    modport slave (
        input  mem_ren, mem_raddrA, mem_raddrB, mem_wen, mem_waddr, mem_wdata,
        output mem_rdataA, mem_rdataB
    );

endinterface

// File: rtl/matrix_ewise_engine_delay_line.sv
// Fixed-depth shift register with per-stage valid and synchronous flush.
module matrix_ewise_engine_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Shift valids and payload one stage per cycle; flush drops every valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid & ~flush;
            data_q[0]  <= in_data;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1] & ~flush;
                data_q[s]  <= data_q[s-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/matrix_ewise_engine.sv
// Multi-lane element-wise matrix ALU: C[i] = op(A[i], B[i]) for i < length.
module matrix_ewise_engine
    import matrix_ewise_engine_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned MEM_DEPTH = 64,
    parameter int unsigned AW        = $clog2(MEM_DEPTH),
    parameter int unsigned RD_LAT    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [1:0]    op,
    input  logic [AW-1:0] baseA,
    input  logic [AW-1:0] baseB,
    input  logic [AW-1:0] baseC,
    input  logic [31:0]   length,
    output logic          busy,
    output logic          done,
    matrix_ewise_engine_if.master mem
);

    localparam int unsigned DLW = LANES + LANES * AW;
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    ewise_state_t state_q, state_d;
    logic [31:0]  idx_q, idx_d;
    logic [1:0]   drain_q, drain_d;
    logic         latch;
    ewise_op_t    op_q;
    logic [AW-1:0] base_a_q, base_b_q, base_c_q;
    logic [31:0]  len_q;

    logic [LANES-1:0]         ren;
    logic [LANES-1:0][AW-1:0] raddr_a, raddr_b, waddr_in;
    logic [32:0]              e;

    logic                     dl_valid;
    logic [DLW-1:0]           dl_data;
    logic [LANES-1:0]         dl_mask;
    logic [LANES-1:0][AW-1:0] dl_waddr;
    logic                     flush;

    logic [LANES-1:0]         wen;
    logic [LANES-1:0][AW-1:0] waddr;
    word_t [LANES-1:0]        wdata;

    // State, chunk index and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
        end
    end

    // Job parameters captured on an accepted start only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= EwAdd;
            base_a_q <= '0;
            base_b_q <= '0;
            base_c_q <= '0;
            len_q    <= '0;
        end else if (latch) begin
            op_q     <= ewise_op_t'(op);
            base_a_q <= baseA;
            base_b_q <= baseB;
            base_c_q <= baseC;
            len_q    <= length;
        end
    end

    // Next-state logic; abort takes priority over start and chunk progress.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    latch   = 1'b1;
                    idx_d   = '0;
                    state_d = (length == 32'd0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 32'(LANES);
                    // 33-bit compare so a length near 2^32 cannot wrap the index.
                    if (({1'b0, idx_q} + 33'(LANES)) >= {1'b0, len_q}) begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Issue stage: per-lane read enables and wrapped read/write addresses.
    always_comb begin
        ren      = '0;
        raddr_a  = '0;
        raddr_b  = '0;
        waddr_in = '0;
        e        = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            e           = {1'b0, idx_q} + 33'(i);
            ren[i]      = (state_q == StIssue) && (e < {1'b0, len_q});
            waddr_in[i] = base_c_q + e[AW-1:0];
            if (ren[i]) begin
                raddr_a[i] = base_a_q + e[AW-1:0];
                raddr_b[i] = base_b_q + e[AW-1:0];
            end
        end
    end

    assign flush = abort && ((state_q == StIssue) || (state_q == StDrain));

    matrix_ewise_engine_delay_line #(
        .DEPTH (RD_LAT),
        .WIDTH (DLW)
    ) u_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (|ren),
        .in_data   ({ren, waddr_in}),
        .out_valid (dl_valid),
        .out_data  (dl_data)
    );

    assign dl_mask  = dl_data[LANES*AW +: LANES];
    assign dl_waddr = dl_data[LANES*AW-1:0];

    // Write stage: delayed mask gates address and ALU result per lane.
    always_comb begin
        wen   = '0;
        waddr = '0;
        wdata = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (dl_valid && dl_mask[i]) begin
                wen[i]   = 1'b1;
                waddr[i] = dl_waddr[i];
                wdata[i] = ewise_alu(op_q, mem.mem_rdataA[i], mem.mem_rdataB[i]);
            end
        end
    end

    assign mem.mem_ren    = ren;
    assign mem.mem_raddrA = raddr_a;
    assign mem.mem_raddrB = raddr_b;
    assign mem.mem_wen    = wen;
    assign mem.mem_waddr  = waddr;
    assign mem.mem_wdata  = wdata;

    assign busy = (state_q == StIssue) || (state_q == StDrain);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_matrix_ewise_engine.sv
// Scoreboard bench: three engines (RD_LAT 1..3, LANES 4) run the same directed jobs.
module tb_matrix_ewise_engine;
    import matrix_ewise_engine_pkg::*;

    localparam int L     = 4;
    localparam int AWB   = 6;
    localparam int DEPTH = 64;
    localparam int NI    = 3;

    typedef struct {
        int                       cyc;
        logic [L-1:0]             mask;
        logic [L-1:0][AWB-1:0]    a0;
        logic [L-1:0][AWB-1:0]    a1;
        logic [L-1:0][31:0]       d;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [1:0]     op = 2'd0;
    logic [AWB-1:0] baseA = '0;
    logic [AWB-1:0] baseB = '0;
    logic [AWB-1:0] baseC = '0;
    logic [31:0]    length = '0;

    logic [31:0] mem [DEPTH];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    bit final_chk = 1'b0;
    bit final_done = 1'b0;

    ev_t ren_q  [NI][$];
    ev_t wr_q   [NI][$];
    int  done_q [NI][$];
    int  bz_from [NI];
    int  bz_to   [NI];

    logic [NI-1:0]                   busy_a, done_a;
    logic [NI-1:0][L-1:0]            ren_a, wen_a;
    logic [NI-1:0][L-1:0][AWB-1:0]   ra_a, rb_a, wa_a;
    logic [NI-1:0][L-1:0][31:0]      wd_a;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int RL = g + 1;
        matrix_ewise_engine_if #(.LANES(L), .AW(AWB)) mif ();
        logic [L-1:0][31:0] pa [RL];
        logic [L-1:0][31:0] pb [RL];

        matrix_ewise_engine #(
            .LANES(L), .MEM_DEPTH(DEPTH), .AW(AWB), .RD_LAT(RL)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
            .baseA(baseA), .baseB(baseB), .baseC(baseC), .length(length),
            .busy(busy_a[g]), .done(done_a[g]), .mem(mif)
        );

        // Synchronous memory with RL cycles of read latency.
        always @(posedge clk) begin
            for (int i = 0; i < L; i++) begin
                pa[0][i] <= mif.mem_ren[i] ? mem[mif.mem_raddrA[i]] : 32'hDEAD_BEEF;
                pb[0][i] <= mif.mem_ren[i] ? mem[mif.mem_raddrB[i]] : 32'hDEAD_BEEF;
            end
            for (int s = 1; s < RL; s++) begin
                pa[s] <= pa[s-1];
                pb[s] <= pb[s-1];
            end
        end

        assign mif.mem_rdataA = pa[RL-1];
        assign mif.mem_rdataB = pb[RL-1];
        assign ren_a[g] = mif.mem_ren;
        assign wen_a[g] = mif.mem_wen;
        assign ra_a[g]  = mif.mem_raddrA;
        assign rb_a[g]  = mif.mem_raddrB;
        assign wa_a[g]  = mif.mem_waddr;
        assign wd_a[g]  = mif.mem_wdata;
    end

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return p[31:0];
            default: return ($signed(a) > $signed(b)) ? a : b;
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc=%0d: got %0h, expected %0h", nm, k, cyc, act, exp);
        end
    endtask

    // Monitor: pops expected events when their cycle arrives, else requires idle outputs.
    always @(negedge clk) begin
        ev_t ev;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                chk("reset_ctrl", k, {busy_a[k], done_a[k], ren_a[k], wen_a[k]}, '0);
                chk("reset_addr", k, {ra_a[k], rb_a[k], wa_a[k]}, '0);
                chk("reset_wdata", k, wd_a[k], '0);
            end else begin
                chk("busy", k, busy_a[k], (cyc >= bz_from[k]) && (cyc <= bz_to[k]));
                if (done_q[k].size() > 0 && done_q[k][0] == cyc) begin
                    void'(done_q[k].pop_front());
                    chk("done_pulse", k, done_a[k], 1'b1);
                end else begin
                    chk("done_idle", k, done_a[k], 1'b0);
                end
                if (ren_q[k].size() > 0 && ren_q[k][0].cyc == cyc) begin
                    ev = ren_q[k].pop_front();
                    chk("ren_mask", k, ren_a[k], ev.mask);
                    for (int i = 0; i < L; i++) begin
                        if (ev.mask[i]) begin
                            chk("raddrA", k, ra_a[k][i], ev.a0[i]);
                            chk("raddrB", k, rb_a[k][i], ev.a1[i]);
                        end
                    end
                end else begin
                    chk("ren_idle", k, ren_a[k], '0);
                end
                if (wr_q[k].size() > 0 && wr_q[k][0].cyc == cyc) begin
                    ev = wr_q[k].pop_front();
                    chk("wen_mask", k, wen_a[k], ev.mask);
                    for (int i = 0; i < L; i++) begin
                        if (ev.mask[i]) begin
                            chk("waddr", k, wa_a[k][i], ev.a0[i]);
                            chk("wdata", k, wd_a[k][i], ev.d[i]);
                        end
                    end
                end else begin
                    chk("wen_idle", k, wen_a[k], '0);
                end
            end
            if (final_chk && !final_done) begin
                chk("leftover_events", k,
                    ren_q[k].size() + wr_q[k].size() + done_q[k].size(), '0);
            end
        end
        if (final_chk) final_done <= 1'b1;
    end

    // Start a job, queue every expected ren/write/done event per instance.
    task automatic run_job(input logic [1:0] o, input int ba, input int bb, input int bc,
                           input int len, input int abort_rel, input bit restart);
        int t0, n, stop, e, rl;
        ev_t rv, wv;
        @(negedge clk);
        t0   = cyc;
        n    = (len + L - 1) / L;
        stop = (abort_rel > 0) ? t0 + abort_rel : 32'h7fff_ffff;
        op = o; baseA = AWB'(ba); baseB = AWB'(bb); baseC = AWB'(bc);
        length = len; start = 1'b1;
        for (int g = 0; g < NI; g++) begin
            rl = g + 1;
            for (int k = 0; k < n; k++) begin
                rv.mask = '0; rv.a0 = '0; rv.a1 = '0; rv.d = '0;
                wv = rv;
                for (int i = 0; i < L; i++) begin
                    e = k * L + i;
                    if (e < len) begin
                        rv.mask[i] = 1'b1;
                        rv.a0[i]   = AWB'((ba + e) % DEPTH);
                        rv.a1[i]   = AWB'((bb + e) % DEPTH);
                        wv.mask[i] = 1'b1;
                        wv.a0[i]   = AWB'((bc + e) % DEPTH);
                        wv.d[i]    = ref_op(o, mem[(ba + e) % DEPTH], mem[(bb + e) % DEPTH]);
                    end
                end
                rv.cyc = t0 + 1 + k;
                wv.cyc = t0 + 1 + k + rl;
                if (rv.cyc <= stop) ren_q[g].push_back(rv);
                if (wv.cyc <= stop) wr_q[g].push_back(wv);
            end
            if (abort_rel == 0) done_q[g].push_back((len == 0) ? t0 + 1 : t0 + n + rl + 1);
            bz_from[g] = t0 + 1;
            bz_to[g]   = (len == 0) ? t0 : ((abort_rel > 0) ? stop : t0 + n + rl);
        end
        @(negedge clk);
        // Scramble inputs: the latched job must not follow them.
        start = 1'b0; op = ~o; baseA = ~baseA; baseB = ~baseB; baseC = ~baseC;
        length = 32'hFFFF;
        if (restart) begin
            @(negedge clk);
            start = 1'b1; length = 0;
            @(negedge clk);
            start = 1'b0;
        end
        if (abort_rel > 0) begin
            repeat (abort_rel - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        repeat (n + 8) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            bz_from[i] = 1;
            bz_to[i]   = 0;
        end
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ADD, partial last chunk, with an ignored second start while busy.
        for (int i = 0; i < 16; i++) begin
            mem[i] = i;
            mem[16 + i] = 32'd100;
        end
        run_job(2'd0, 0, 16, 40, 10, 0, 1'b1);

        // SUB wraps: 5 - 7.
        for (int i = 0; i < 8; i++) begin
            mem[i] = 32'd5;
            mem[16 + i] = 32'd7;
        end
        run_job(2'd1, 0, 16, 40, 8, 0, 1'b0);

        // MAX signed.
        mem[0] = 32'h8000_0000; mem[1] = 32'd5; mem[2] = 32'hFFFF_FFFD; mem[3] = 32'd7;
        mem[16] = 32'd1; mem[17] = 32'd3; mem[18] = 32'hFFFF_FFFE; mem[19] = 32'd7;
        run_job(2'd3, 0, 16, 40, 4, 0, 1'b0);

        // MUL low 32 bits.
        mem[0] = 32'h0001_0000; mem[1] = 32'd3; mem[2] = 32'hFFFF_FFFF; mem[3] = 32'h1_2345;
        mem[16] = 32'h0001_0000; mem[17] = 32'd5; mem[18] = 32'd2; mem[19] = 32'h10;
        run_job(2'd2, 0, 16, 40, 4, 0, 1'b0);

        // Zero length.
        run_job(2'd0, 0, 16, 40, 0, 0, 1'b0);

        // Abort in cycle 2 of a 16-element job, then a normal job.
        for (int i = 0; i < 16; i++) mem[i] = i;
        run_job(2'd0, 0, 16, 40, 16, 2, 1'b0);

        // Address wrap on reads and writes.
        mem[62] = 32'd10; mem[63] = 32'd20; mem[0] = 32'd30; mem[1] = 32'd40;
        mem[16] = 32'd1; mem[17] = 32'd2; mem[18] = 32'd3; mem[19] = 32'd4;
        run_job(2'd0, 62, 16, 62, 4, 0, 1'b0);

        // start with abort in IDLE, then abort alone in IDLE: nothing happens.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; length = 4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        repeat (8) @(negedge clk);

        final_chk = 1'b1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_ewise_engine.md
Name: matrix_ewise_engine

Overview:
Multi-lane, element-wise matrix ALU engine. Generalises the single-op matrix-add engine in four ways: selectable opcode, configurable synchronous-memory read latency, abort support, and a pipelined issue/write path. Each cycle it processes one chunk of LANES elements: C[i] = op(A[i], B[i]) for i in 0..length-1. It sits between the shader command decoder and the banked per-lane scratch memory.

Parameters:
LANES, lanes (GPU_Shader_pkg), elements issued per cycle; 1..16
AW, $clog2(MEM_DEPTH), word-address width
RD_LAT, 1, memory read latency in cycles, from address to rdata; 1..4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  sampled in IDLE only; ignored while busy
abort  in  1  synchronous flush; returns to IDLE without done
op  in  2  ewise_op_t: ADD=0, SUB=1 (A-B), MUL=2 (low 32 bits), MAX=3 (signed)
baseA, baseB, baseC  in  AW each  word-address bases
length  in  32  element count; 0 is legal
busy  out  1  high while issuing or draining
done  out  1  one-cycle completion pulse
mem_ren  out  LANES  per-lane read enable
mem_raddrA, mem_raddrB  out  LANES x AW  per-lane read addresses
mem_rdataA, mem_rdataB  in  LANES x word_t  read data, valid RD_LAT cycles after ren
mem_wen  out  LANES  per-lane write enable
mem_waddr  out  LANES x AW  per-lane write address
mem_wdata  out  LANES x word_t  per-lane write data

Behaviour:
- Reset: state=IDLE, idx=0, busy=0, done=0, mem_ren=0, mem_wen=0, delay-line valids=0. All address and data outputs are 0.
- start in IDLE latches op, the three bases, and length. Later input changes have no effect until the next start.
- States:
  - IDLE: start with length>0 -> ISSUE; start with length==0 -> DONE.
  - ISSUE: each cycle issues the chunk at idx, then idx += LANES. The chunk with idx+LANES >= length -> DRAIN.
  - DRAIN: waits RD_LAT cycles, then -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Issue: lane i has element e=idx+i. mem_ren[i]=(state==ISSUE)&&(e<length). Read addresses are baseA+e and baseB+e, truncated to AW bits (wrap modulo MEM_DEPTH).
- Delay line: RD_LAT stages carrying the lane mask and write addresses (baseC+e, wrapped).
- Write stage: mem_wen = delayed mask. mem_wdata is computed combinationally from rdata and the latched op.
- Arithmetic: ADD, SUB and MUL wrap modulo 2^32. MAX compares as signed 32-bit.
- Timing, with start sampled at edge 0 and N=ceil(length/LANES):
  - chunk k issued in cycle 1+k;
  - chunk k written in cycle 1+k+RD_LAT;
  - done in cycle N+RD_LAT+1;
  - busy high in cycles 1..N+RD_LAT.
- length==0: no ren and no wen. busy stays 0. done pulses in cycle 1.
- Partial final chunk: lanes with e>=length have ren=0 and wen=0.
- abort in ISSUE or DRAIN: next cycle state=IDLE, busy=0, done=0, all delay-line valids cleared. No writes follow the abort cycle.
- abort in IDLE or DONE: no effect.
- start and abort high together in IDLE: abort wins and start is ignored.
- Overlapping read/write ranges are not hazard-checked; software guarantees disjoint C, or C==A with identical alignment.
- Async reset mid-operation: all outputs return to reset values immediately.

Decomposition:
- GPU_Shader_pkg gains:
  - ewise_op_t (2-bit enum);
  - EWISE_MAX_RD_LAT=4;
  - function ewise_alu(op, a, b) returning word_t.
- Sub-module ewise_delay_line: parametrised by DEPTH and WIDTH, with a valid bit and synchronous flush. One instance carries {mask, waddr}.

Test Plan:
- LANES=4, RD_LAT=1, ADD, length=10, A[i]=i, B[i]=100:
  - ren masks 1111, 1111, 0011 in cycles 1-3;
  - writes in cycles 2-4 with C[i]=i+100;
  - done in cycle 5; C[10..11] untouched.
- RD_LAT=3, SUB, length=8, A=5, B=7:
  - C=0xFFFFFFFE;
  - first write in cycle 4, done in cycle 6.
- MAX with A=0x80000000 and B=1 -> C=1. MUL with 0x10000 x 0x10000 -> C=0.
- length=0 start -> no ren or wen, busy=0, done in cycle 1. A second start while busy is ignored.
- abort in cycle 2 of a length=16, LANES=4, RD_LAT=2 job -> no wen from cycle 3 on, done never pulses, then a new start completes normally.
- baseA=MEM_DEPTH-2, length=4 -> read addresses MEM_DEPTH-2, MEM_DEPTH-1, 0, 1.
